mac_operand_loader: RTL and testbench
=====================================

MAC_OPERAND_LOADER -- requirements
Module: mac_operand_loader

Interface
REQ-001 Parameter: MAC_LATENCY, default 5, cycles from mac_issue to valid MAC result (depth of the downstream MAC pipeline).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 s_valid  input  1  upstream operand byte valid.
REQ-005 s_ready  output  1  loader accepts s_data this cycle.
REQ-006 s_data  input  8  operand byte: image byte, or weight in bits [3:0].
REQ-007 s_is_weight  input  1  1 = s_data is a weight nibble; 0 = image byte.
REQ-008 cfg_wr  input  1  load cfg_bias into exp_bias.
REQ-009 cfg_bias  input  5  exponent bias value.
REQ-010 image  output  72  issued 3x3 image window, element 0 in [71:64], element 8 in [7:0].
REQ-011 weight  output  36  issued 3x3 kernel, element 0 in [35:32], element 8 in [3:0].
REQ-012 exp_bias  output  5  registered exponent bias.
REQ-013 mac_issue  output  1  one-cycle pulse: image/weight hold a new operand set.
REQ-014 res_valid  output  1  MAC output valid, mac_issue delayed MAC_LATENCY cycles.
REQ-015 issue_count  output  16  number of windows issued since reset.
REQ-016 err_proto  output  1  one-cycle pulse on protocol violation.

Function
REQ-017 Transfer occurs when s_valid and s_ready are both 1; no other cycle changes assembly state.
REQ-018 FSM states: IDLE, LOAD_W, LOAD_I, ISSUE; 4-bit element index idx in 0..8.
REQ-019 IDLE: s_ready=1; weight transfer -> store nibble at element 0, idx=1, go LOAD_W; image transfer -> dropped, err_proto pulse, stay IDLE.
REQ-020 LOAD_W: s_ready=1; weight transfer stores s_data[3:0] at element idx of weight shadow; on idx=8 go LOAD_I with idx=0; image transfer while idx!=0 -> err_proto, discard partial kernel, go IDLE.
REQ-021 LOAD_I: s_ready=1; image transfer stores s_data at element idx of image shadow; on idx=8 go ISSUE.
REQ-022 LOAD_I weight transfer with idx=0 starts a new kernel (element 0, idx=1, LOAD_W), no error; with idx!=0 -> err_proto, discard partial window, same kernel restart.
REQ-023 ISSUE (exactly one cycle): s_ready=0; image and weight outputs loaded from shadows; mac_issue=1 the following cycle, aligned with new output values; go LOAD_I, idx=0.
REQ-024 Kernel reuse: after one kernel load, every further 9 image bytes produce one issue with the same weight.
REQ-025 image/weight outputs change only on issue; shadow loading never disturbs them.
REQ-026 Minimum issue interval: 10 cycles (9 transfers + ISSUE); back-to-back s_valid sustains this rate.
REQ-027 res_valid: MAC_LATENCY-deep shift register of mac_issue; res_valid high exactly MAC_LATENCY cycles after each mac_issue pulse.
REQ-028 issue_count increments by 1 per mac_issue, wraps 16'hFFFF -> 0.
REQ-029 cfg_wr: exp_bias <= cfg_bias next edge in any state; takes effect for the next issue; cfg_wr same cycle as issue is applied and visible with that issue.

Reset
REQ-030 rst asserted (any cycle, including mid-load or mid-issue): FSM=IDLE, idx=0, shadows=0, image=0, weight=0, exp_bias=0, mac_issue=0, res_valid pipeline cleared, issue_count=0, err_proto=0, s_ready=0 while rst high, 1 in the first cycle after release.
REQ-031 In-flight res_valid pulses are lost on reset; no res_valid emitted after release until a new issue.

Verification
REQ-032 Weights 1..9, then image bytes 8'h10..8'h18 back-to-back -> weight=36'h123456789, image=72'h101112131415161718, mac_issue one cycle, res_valid 5 cycles later, issue_count=1.
REQ-033 After REQ-032, 9 more image bytes 8'hA0..8'hA8 -> second issue, weight unchanged 36'h123456789, issue_count=2, 10-cycle spacing between issues.
REQ-034 Weight byte after 4 image bytes -> err_proto pulse, no issue, new kernel load begins; prior image/weight outputs unchanged.
REQ-035 Image byte in IDLE after reset -> err_proto pulse, state stays IDLE, s_ready=1.
REQ-036 rst asserted 2 cycles after an issue -> all outputs 0 asynchronously, no res_valid afterward.
REQ-037 issue_count preset by 65535 issues -> next issue wraps to 0; cfg_wr with cfg_bias=5'd15 -> exp_bias=15 next cycle.

Source files
------------

// File: rtl/mac_operand_loader.sv
// Assembles a 3x3 weight kernel and 3x3 image windows from a byte stream and issues
// operand sets to a downstream MAC pipeline, tracking result validity and issue count.
module mac_operand_loader #(
  parameter int unsigned MAC_LATENCY = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_is_weight,
  input  logic        cfg_wr,
  input  logic [4:0]  cfg_bias,
  output logic [71:0] image,
  output logic [35:0] weight,
  output logic [4:0]  exp_bias,
  output logic        mac_issue,
  output logic        res_valid,
  output logic [15:0] issue_count,
  output logic        err_proto
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_W = 2'd1;
  localparam logic [1:0] LOAD_I = 2'd2;
  localparam logic [1:0] ISSUE  = 2'd3;

  // A width of at least 2 keeps the shift concatenation legal when MAC_LATENCY is 1.
  localparam int unsigned PipeW = (MAC_LATENCY > 1) ? MAC_LATENCY : 2;

  logic [1:0]          state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  // Element 0 sits in the most significant slot so shadows map straight onto the outputs.
  logic [0:8][3:0]     wsh_q, wsh_d;
  logic [0:8][7:0]     ish_q, ish_d;
  logic                err_d;
  logic                transfer;

  logic [71:0]         image_q;
  logic [35:0]         weight_q;
  logic [4:0]          exp_bias_q;
  logic                mac_issue_q;
  logic [PipeW-1:0]    res_pipe_q;
  logic [15:0]         issue_count_q;
  logic                err_q;

  assign s_ready  = !rst && (state_q != ISSUE);
  assign transfer = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wsh_d   = wsh_q;
    ish_d   = ish_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          if (s_is_weight) begin
            wsh_d[0] = s_data[3:0];
            idx_d    = 4'd1;
            state_d  = LOAD_W;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_W: begin
        if (transfer) begin
          if (s_is_weight) begin
            wsh_d[idx_q] = s_data[3:0];
            if (idx_q == 4'd8) begin
              idx_d   = 4'd0;
              state_d = LOAD_I;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else if (idx_q != 4'd0) begin
            err_d   = 1'b1;
            idx_d   = 4'd0;
            state_d = IDLE;
          end
        end
      end
      LOAD_I: begin
        if (transfer) begin
          if (s_is_weight) begin
            // A weight here always restarts the kernel; it is only an error mid-window.
            err_d    = (idx_q != 4'd0);
            wsh_d[0] = s_data[3:0];
            idx_d    = 4'd1;
            state_d  = LOAD_W;
          end else begin
            ish_d[idx_q] = s_data;
            if (idx_q == 4'd8) begin
              idx_d   = 4'd0;
              state_d = ISSUE;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      end
      ISSUE: begin
        idx_d   = 4'd0;
        state_d = LOAD_I;
      end
      default: begin
        idx_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      wsh_q   <= '0;
      ish_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wsh_q   <= wsh_d;
      ish_q   <= ish_d;
      err_q   <= err_d;
    end
  end

  // Outputs and count update on the edge leaving ISSUE, so they align with mac_issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      image_q       <= '0;
      weight_q      <= '0;
      mac_issue_q   <= 1'b0;
      issue_count_q <= '0;
    end else begin
      mac_issue_q <= (state_q == ISSUE);
      if (state_q == ISSUE) begin
        image_q       <= ish_q;
        weight_q      <= wsh_q;
        issue_count_q <= issue_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_bias_q <= '0;
    end else if (cfg_wr) begin
      exp_bias_q <= cfg_bias;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_pipe_q <= '0;
    end else begin
      res_pipe_q <= {res_pipe_q[PipeW-2:0], mac_issue_q};
    end
  end

  assign image       = image_q;
  assign weight      = weight_q;
  assign exp_bias    = exp_bias_q;
  assign mac_issue   = mac_issue_q;
  assign res_valid   = res_pipe_q[MAC_LATENCY-1];
  assign issue_count = issue_count_q;
  assign err_proto   = err_q;

endmodule

// File: tb/tb_mac_operand_loader.sv
// Randomized and directed bench for mac_operand_loader, checked each cycle against a
// count-based reference model of kernel/window assembly.
module tb_mac_operand_loader;

  localparam int unsigned L = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_is_weight;
  logic        cfg_wr;
  logic [4:0]  cfg_bias;
  logic [71:0] image;
  logic [35:0] weight;
  logic [4:0]  exp_bias;
  logic        mac_issue;
  logic        res_valid;
  logic [15:0] issue_count;
  logic        err_proto;

  mac_operand_loader #(.MAC_LATENCY(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_is_weight (s_is_weight),
    .cfg_wr      (cfg_wr),
    .cfg_bias    (cfg_bias),
    .image       (image),
    .weight      (weight),
    .exp_bias    (exp_bias),
    .mac_issue   (mac_issue),
    .res_valid   (res_valid),
    .issue_count (issue_count),
    .err_proto   (err_proto)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: counts of collected nibbles/bytes plus expected output registers.
  logic [3:0]  m_wn [9];
  logic [7:0]  m_img[9];
  int          m_wcnt;
  int          m_icnt;
  bit          m_have;
  bit          m_issuing;
  logic [71:0] e_image;
  logic [35:0] e_weight;
  logic [4:0]  e_bias;
  logic [15:0] e_count;
  bit          e_mac;
  bit          e_err;
  logic [63:0] hist;

  int          cyc;
  int          n_issues;
  int          issue_cyc[2];
  logic [71:0] issue_img[2];
  logic [35:0] issue_w[2];
  logic [15:0] issue_cnt[2];
  logic [15:0] last_cnt;
  int          res1_cyc;
  int          n_err;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m_wn[i]  = '0;
      m_img[i] = '0;
    end
    m_wcnt = 0; m_icnt = 0; m_have = 0; m_issuing = 0;
    e_image = '0; e_weight = '0; e_bias = '0; e_count = '0;
    e_mac = 0; e_err = 0; hist = '0;
  endtask

  task automatic model_step(input bit xfer, input bit w, input logic [7:0] d,
                            input bit cw, input logic [4:0] cb);
    e_mac = m_issuing;
    e_err = 0;
    if (m_issuing) begin
      e_image  = '0;
      e_weight = '0;
      for (int i = 0; i < 9; i++) begin
        e_image  = (e_image << 8) | 72'(m_img[i]);
        e_weight = (e_weight << 4) | 36'(m_wn[i]);
      end
      e_count   = e_count + 16'd1;
      m_issuing = 0;
    end
    if (cw) e_bias = cb;
    if (xfer) begin
      if (w) begin
        if (m_have && m_icnt > 0) e_err = 1;
        if (m_have || m_wcnt == 0) begin
          m_have = 0;
          m_wcnt = 0;
          m_icnt = 0;
        end
        m_wn[m_wcnt] = d[3:0];
        m_wcnt++;
        if (m_wcnt == 9) begin
          m_have = 1;
          m_wcnt = 0;
          m_icnt = 0;
        end
      end else if (!m_have) begin
        e_err  = 1;
        m_wcnt = 0;
      end else begin
        m_img[m_icnt] = d;
        m_icnt++;
        if (m_icnt == 9) begin
          m_issuing = 1;
          m_icnt    = 0;
        end
      end
    end
    hist = {hist[62:0], e_mac};
  endtask

  task automatic tick(input bit v, input bit w, input logic [7:0] d, input bit cw,
                      input logic [4:0] cb, output bit xfer);
    bit rdy;
    @(negedge clk);
    s_valid = v; s_is_weight = w; s_data = d; cfg_wr = cw; cfg_bias = cb;
    rdy = !m_issuing;
    #1 chk("s_ready", 72'(s_ready), 72'(rdy));
    xfer = v && rdy;
    @(posedge clk);
    model_step(xfer, w, d, cw, cb);
    cyc++;
    #1;
    chk("mac_issue", 72'(mac_issue), 72'(e_mac));
    chk("err_proto", 72'(err_proto), 72'(e_err));
    chk("image", image, e_image);
    chk("weight", 72'(weight), 72'(e_weight));
    chk("issue_count", 72'(issue_count), 72'(e_count));
    chk("exp_bias", 72'(exp_bias), 72'(e_bias));
    chk("res_valid", 72'(res_valid), 72'(hist[L]));
    if (err_proto) n_err++;
    if (mac_issue) begin
      last_cnt = issue_count;
      if (n_issues < 2) begin
        issue_cyc[n_issues] = cyc;
        issue_img[n_issues] = image;
        issue_w[n_issues]   = weight;
        issue_cnt[n_issues] = issue_count;
      end
      n_issues++;
    end
    if (res_valid && res1_cyc < 0) res1_cyc = cyc;
  endtask

  task automatic idle(input int n);
    bit x;
    for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 0, 5'd0, x);
  endtask

  // Holds the byte until accepted; bounded so a stuck s_ready cannot hang the run.
  task automatic send(input bit w, input logic [7:0] d);
    bit x;
    int n = 0;
    do begin
      tick(1, w, d, 0, 5'd0, x);
      n++;
    end while (!x && n < 4);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"}, 72'(s_ready), 72'(0));
    chk({tag, "_image"}, image, 72'(0));
    chk({tag, "_weight"}, 72'(weight), 72'(0));
    chk({tag, "_count"}, 72'(issue_count), 72'(0));
    chk({tag, "_bias"}, 72'(exp_bias), 72'(0));
    chk({tag, "_mac"}, 72'(mac_issue), 72'(0));
    chk({tag, "_res"}, 72'(res_valid), 72'(0));
    chk({tag, "_err"}, 72'(err_proto), 72'(0));
  endtask

  initial begin
    bit x;
    bit v, w, cw;
    logic [7:0] d;
    int err_before;
    int issues_before;

    rst = 1'b1; s_valid = 0; s_is_weight = 0; s_data = '0; cfg_wr = 0; cfg_bias = '0;
    cyc = 0; n_issues = 0; res1_cyc = -1; n_err = 0; last_cnt = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    #1 chk("ready_after_release", 72'(s_ready), 72'(1));

    // Image byte with no kernel loaded.
    send(0, 8'h55);
    chk("idle_image_err", 72'(err_proto), 72'(1));
    chk("idle_ready", 72'(s_ready), 72'(1));

    tick(0, 0, 8'h00, 1, 5'd15, x);
    chk("bias_15", 72'(exp_bias), 72'(15));

    // Kernel 1..9, then two windows back-to-back.
    for (int i = 1; i <= 9; i++) send(1, 8'(i));
    for (int i = 0; i < 9; i++) send(0, 8'h10 + 8'(i));
    for (int i = 0; i < 9; i++) send(0, 8'hA0 + 8'(i));
    idle(8);
    chk("issue_seen", 72'(n_issues), 72'(2));
    chk("issue1_weight", 72'(issue_w[0]), 72'(36'h123456789));
    chk("issue1_image", issue_img[0], 72'h101112131415161718);
    chk("issue1_count", 72'(issue_cnt[0]), 72'(1));
    chk("res_latency", 72'(res1_cyc - issue_cyc[0]), 72'(L));
    chk("issue2_weight", 72'(issue_w[1]), 72'(36'h123456789));
    chk("issue2_image", issue_img[1], 72'hA0A1A2A3A4A5A6A7A8);
    chk("issue2_count", 72'(issue_cnt[1]), 72'(2));
    chk("issue_spacing", 72'(issue_cyc[1] - issue_cyc[0]), 72'(10));

    // Weight arriving mid-window.
    err_before = n_err;
    issues_before = n_issues;
    for (int i = 0; i < 4; i++) send(0, 8'hC0 + 8'(i));
    send(1, 8'h0F);
    idle(2);
    chk("midwin_err", 72'(n_err - err_before), 72'(1));
    chk("midwin_no_issue", 72'(n_issues - issues_before), 72'(0));
    chk("midwin_image_kept", image, 72'hA0A1A2A3A4A5A6A7A8);
    for (int i = 1; i < 9; i++) send(1, 8'($urandom));
    for (int i = 0; i < 9; i++) send(0, 8'($urandom));
    idle(3);

    // Random traffic steered mostly toward legal sequences.
    for (int i = 0; i < 500; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      w  = !m_have;
      if ($urandom_range(0, 11) == 0) w = !w;
      cw = ($urandom_range(0, 7) == 0);
      d  = 8'($urandom);
      tick(v, w, d, cw, 5'($urandom), x);
    end
    idle(8);

    // Count wrap: preset the counter just below rollover.
    if (!m_have) for (int i = 0; i < 9; i++) send(1, 8'($urandom));
    @(negedge clk);
    force dut.issue_count_q = 16'hFFFF;
    #1 release dut.issue_count_q;
    e_count = 16'hFFFF;
    for (int i = 0; i < 9; i++) send(0, 8'($urandom));
    idle(2);
    chk("count_wrap", 72'(last_cnt), 72'(0));

    // Reset two cycles after an issue drops the pending result.
    for (int i = 0; i < 9; i++) send(0, 8'($urandom));
    idle(3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    res1_cyc = -1;
    idle(10);
    chk("no_res_after_rst", 72'(res1_cyc), 72'(-1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
